// File: rtl/phase_sweep_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phase_sweep_sequencer_pkg
// Description : Shared types for the phase sweep sequencer: state encoding,
//               latched sweep configuration and the repeat-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package phase_sweep_sequencer_pkg;

    localparam int C_PHASE_W  = 16;
    localparam int C_STEP_W   = 8;
    localparam int C_REPEAT_W = 8;

    // 8-bit encoding so the value can be fed straight into the scenario debug mux
    typedef enum logic [7:0] {
        ST_IDLE   = 8'h00,
        ST_LOAD   = 8'h01,
        ST_ARM    = 8'h02,
        ST_RUN    = 8'h03,
        ST_SETTLE = 8'h04,
        ST_NEXT   = 8'h05,
        ST_DONE   = 8'h06,
        ST_ERROR  = 8'h07
    } sweep_state_t;

    // Configuration held for the whole sweep; the start phase is not kept here
    // because it goes straight into the phase accumulator on LOAD.
    typedef struct packed {
        logic [C_PHASE_W-1:0]  phase_step;
        logic [C_PHASE_W-1:0]  phase_period;
        logic [C_STEP_W-1:0]   steps;
        logic [C_REPEAT_W-1:0] repeats;
    } sweep_cfg_t;

    // A repeat count of zero still runs the calibration FSM once per step
    function automatic logic [C_REPEAT_W-1:0] f_eff_repeats(input logic [C_REPEAT_W-1:0] repeats);
        return (repeats == '0) ? C_REPEAT_W'(1) : repeats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_sweep_sequencer_phase_step_accum.sv
`default_nettype none
// ============================================================================
// Module      : phase_step_accum
// Description : Registered modulo adder holding the current phase shift.
//               Load takes priority over advance; advance adds the step and
//               wraps by one period using a one-bit-wider sum.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_step_accum #(
    parameter int PHASE_W = 16
) (
    input  logic               clock,
    input  logic               reset_signal,
    input  logic               i_load,
    input  logic [PHASE_W-1:0] i_load_value,
    input  logic               i_advance,
    input  logic [PHASE_W-1:0] i_step,
    input  logic [PHASE_W-1:0] i_period,
    output logic [PHASE_W-1:0] o_phase_shift
);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W:0]   w_sum;
    logic [PHASE_W:0]   w_wrapped;

    // Candidate next phase with and without the period subtracted
    always_comb begin
        w_sum     = {1'b0, r_phase} + {1'b0, i_step};
        w_wrapped = w_sum - {1'b0, i_period};
    end

    // Phase register: load the start value or step forward modulo the period
    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            r_phase <= '0;
        end else if (i_load) begin
            r_phase <= i_load_value;
        end else if (i_advance) begin
            r_phase <= (w_sum >= {1'b0, i_period}) ? w_wrapped[PHASE_W-1:0] : w_sum[PHASE_W-1:0];
        end
    end

    assign o_phase_shift = r_phase;

endmodule
`default_nettype wire

// File: rtl/phase_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sweep_sequencer
// Description : Runs a phase-calibration sweep. For each step it programs the
//               phase shift, starts the calibration FSM, counts cfg_repeats
//               trigger edges, waits for detector_ready and advances the
//               phase modulo the period.
//               Optional build macro SWEEP_TIMEOUT_EN adds a per-step watchdog
//               that moves the sweep to ERROR after TIMEOUT_CYCLES.
//               PHASE_W/STEP_W/REPEAT_W must match the package widths.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sweep_sequencer
    import phase_sweep_sequencer_pkg::*;
#(
    parameter int          PHASE_W        = C_PHASE_W,
    parameter int          STEP_W         = C_STEP_W,
    parameter int          REPEAT_W       = C_REPEAT_W,
    parameter int unsigned TIMEOUT_CYCLES = 4_000_000
) (
    input  logic                clock,
    input  logic                reset_signal,
    input  logic                start,
    input  logic                abort,
    input  logic [PHASE_W-1:0]  cfg_phase_start,
    input  logic [PHASE_W-1:0]  cfg_phase_step,
    input  logic [PHASE_W-1:0]  cfg_phase_period,
    input  logic [STEP_W-1:0]   cfg_steps,
    input  logic [REPEAT_W-1:0] cfg_repeats,
    input  logic                fsm_trigger,
    input  logic                detector_ready,
    output logic                fsm_start,
    output logic                fsm_enable,
    output logic [PHASE_W-1:0]  phase_shift,
    output logic [STEP_W-1:0]   step_index,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [7:0]          sweep_state
);

    sweep_state_t        r_state;
    sweep_state_t        w_state_nxt;
    sweep_cfg_t          r_cfg;
    logic [STEP_W-1:0]   r_step;
    logic [REPEAT_W-1:0] r_trig_cnt;
    logic                r_trig_d;
    logic                r_done;

    logic                w_trig_rise;
    logic                w_trig_last;
    logic                w_last_step;
    logic                w_idle_like;
    logic                w_accept_start;
    logic                w_timeout;

    assign w_trig_rise    = fsm_trigger & ~r_trig_d;
    assign w_trig_last    = ((r_trig_cnt + 1'b1) == f_eff_repeats(r_cfg.repeats));
    assign w_last_step    = (r_step == (r_cfg.steps - 1'b1));
    assign w_idle_like    = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign w_accept_start = w_idle_like && start && !abort;

    // State register
    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort overrides every other input in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start) w_state_nxt = ST_LOAD;
                ST_LOAD:   w_state_nxt = (cfg_steps == '0) ? ST_DONE : ST_ARM;
                ST_ARM:    w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_timeout)                      w_state_nxt = ST_ERROR;
                    else if (w_trig_rise && w_trig_last) w_state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_timeout)           w_state_nxt = ST_ERROR;
                    else if (detector_ready) w_state_nxt = ST_NEXT;
                end
                ST_NEXT:   w_state_nxt = w_last_step ? ST_DONE : ST_ARM;
                ST_DONE,
                ST_ERROR:  if (start) w_state_nxt = ST_LOAD;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Sweep bookkeeping: config latch, step counter, trigger counter, done flag
    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            r_cfg      <= '0;
            r_step     <= '0;
            r_trig_cnt <= '0;
            r_trig_d   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_trig_d <= fsm_trigger;
            if (w_accept_start) begin
                r_done <= 1'b0;
            end else if (!abort && (r_state == ST_DONE)) begin
                r_done <= 1'b1;
            end
            if (!abort) begin
                case (r_state)
                    ST_LOAD: begin
                        r_cfg.phase_step   <= cfg_phase_step;
                        r_cfg.phase_period <= cfg_phase_period;
                        r_cfg.steps        <= cfg_steps;
                        r_cfg.repeats      <= cfg_repeats;
                        r_step             <= '0;
                        r_trig_cnt         <= '0;
                    end
                    ST_RUN: begin
                        if (w_trig_rise) r_trig_cnt <= r_trig_cnt + 1'b1;
                    end
                    ST_NEXT: begin
                        r_trig_cnt <= '0;
                        if (!w_last_step) r_step <= r_step + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    phase_step_accum #(
        .PHASE_W (PHASE_W)
    ) u_accum (
        .clock         (clock),
        .reset_signal  (reset_signal),
        .i_load        ((r_state == ST_LOAD) && !abort),
        .i_load_value  (cfg_phase_start),
        .i_advance     ((r_state == ST_NEXT) && !abort && !w_last_step),
        .i_step        (r_cfg.phase_step),
        .i_period      (r_cfg.phase_period),
        .o_phase_shift (phase_shift)
    );

`ifdef SWEEP_TIMEOUT_EN
    localparam int C_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_WD_W-1:0] r_wd_cnt;
    logic              r_error;

    assign w_timeout = ((r_state == ST_RUN) || (r_state == ST_SETTLE)) &&
                       (r_wd_cnt == C_WD_W'(TIMEOUT_CYCLES - 1));

    // Per-step watchdog: restarts on every ARM, counts while waiting on the FSM or detector
    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            r_wd_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            if (r_state == ST_ARM) begin
                r_wd_cnt <= '0;
            end else if ((r_state == ST_RUN) || (r_state == ST_SETTLE)) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_accept_start) begin
                r_error <= 1'b0;
            end else if (!abort && (r_state == ST_ERROR)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign error = r_error;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign error            = 1'b0;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

    assign fsm_start   = (r_state == ST_ARM);
    assign fsm_enable  = (r_state == ST_ARM) || (r_state == ST_RUN);
    assign busy        = !w_idle_like;
    assign done        = r_done;
    assign step_index  = r_step;
    assign sweep_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_phase_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_sweep_sequencer
// Description : Scoreboard bench for phase_sweep_sequencer with a behavioural
//               calibration-FSM emulator and randomized sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sweep_sequencer;
    import phase_sweep_sequencer_pkg::*;

    localparam int PHASE_W  = 16;
    localparam int STEP_W   = 8;
    localparam int REPEAT_W = 8;

    logic                clock = 1'b0;
    logic                reset_signal = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [PHASE_W-1:0]  cfg_phase_start = '0;
    logic [PHASE_W-1:0]  cfg_phase_step = '0;
    logic [PHASE_W-1:0]  cfg_phase_period = '0;
    logic [STEP_W-1:0]   cfg_steps = '0;
    logic [REPEAT_W-1:0] cfg_repeats = '0;
    logic                fsm_trigger = 1'b0;
    logic                detector_ready = 1'b0;
    logic                fsm_start;
    logic                fsm_enable;
    logic [PHASE_W-1:0]  phase_shift;
    logic [STEP_W-1:0]   step_index;
    logic                busy;
    logic                done;
    logic                error;
    logic [7:0]          sweep_state;

    phase_sweep_sequencer #(
        .PHASE_W        (PHASE_W),
        .STEP_W         (STEP_W),
        .REPEAT_W       (REPEAT_W),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clock            (clock),
        .reset_signal     (reset_signal),
        .start            (start),
        .abort            (abort),
        .cfg_phase_start  (cfg_phase_start),
        .cfg_phase_step   (cfg_phase_step),
        .cfg_phase_period (cfg_phase_period),
        .cfg_steps        (cfg_steps),
        .cfg_repeats      (cfg_repeats),
        .fsm_trigger      (fsm_trigger),
        .detector_ready   (detector_ready),
        .fsm_start        (fsm_start),
        .fsm_enable       (fsm_enable),
        .phase_shift      (phase_shift),
        .step_index       (step_index),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .sweep_state      (sweep_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int phase;
        int step;
        int rep;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fsm_start = 0;
    int   em_rises = 0;
    int   em_lo = 0;
    int   em_hi = 0;
    bit   em_quiet = 1'b0;
    int   abort_step = -1;
    int   abort_rise = 0;
    int   ready_mode = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: step k of a sweep presents phase (start + k*step) mod period
    task automatic push_sweep(input int ps, input int st, input int per, input int steps, input int reps);
        for (int k = 0; k < steps; k++) begin
            exp_t e;
            e.phase = (ps + k * st) % per;
            e.step  = k;
            e.rep   = (reps == 0) ? 1 : reps;
            sb_q.push_back(e);
        end
    endtask

    task automatic run_cfg(input int ps, input int st, input int per, input int steps, input int reps);
        @(negedge clock);
        cfg_phase_start  = PHASE_W'(ps);
        cfg_phase_step   = PHASE_W'(st);
        cfg_phase_period = PHASE_W'(per);
        cfg_steps        = STEP_W'(steps);
        cfg_repeats      = REPEAT_W'(reps);
        push_sweep(ps, st, per, steps, reps);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [7:0] s, input int budget, input string name);
        int n = 0;
        while (sweep_state !== s && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, "_state_reached"}, sweep_state, s);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, "_done"}, done, 1);
    endtask

    // Calibration FSM emulator: random-width trigger pulses while enabled
    initial begin
        forever begin
            @(negedge clock);
            abort = 1'b0;
            if (!reset_signal || !fsm_enable) begin
                fsm_trigger = 1'b0;
                em_lo = $urandom_range(1, 3);
            end else if (fsm_start) begin
                fsm_trigger = 1'b0;
                em_rises = 0;
                em_lo = $urandom_range(1, 3);
            end else if (em_quiet) begin
                fsm_trigger = 1'b0;
            end else if (!fsm_trigger) begin
                if (em_lo == 0) begin
                    fsm_trigger = 1'b1;
                    em_hi = $urandom_range(1, 3);
                    em_rises++;
                    if (abort_step >= 0 && int'(step_index) == abort_step && em_rises == abort_rise) begin
                        abort = 1'b1;
                        abort_step = -1;
                    end
                end else begin
                    em_lo--;
                end
            end else begin
                if (em_hi <= 1) begin
                    fsm_trigger = 1'b0;
                    em_lo = $urandom_range(1, 3);
                end else begin
                    em_hi--;
                end
            end
        end
    end

    // Detector ready: random level unless a directed test owns it
    initial begin
        forever begin
            @(negedge clock);
            if (ready_mode == 0) detector_ready = ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: consumes one scoreboard entry per fsm_start and checks step trigger counts
    initial begin
        bit   prev_en = 1'b0;
        bit   prev_done = 1'b0;
        int   cur_rep = 0;
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (!reset_signal) begin
                prev_en = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (fsm_start) begin
                    n_fsm_start++;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_fsm_start: got a pulse at step %0d, expected none", step_index);
                    end else begin
                        e = sb_q.pop_front();
                        check("arm_phase_shift", phase_shift, e.phase);
                        check("arm_step_index", step_index, e.step);
                        cur_rep = e.rep;
                    end
                end
                if (prev_en && !fsm_enable && !abort && !em_quiet)
                    check("triggers_per_step", em_rises, cur_rep);
                if (done && !prev_done)
                    check("done_pending_steps", sb_q.size(), 0);
                prev_en = fsm_enable;
                prev_done = done;
            end
        end
    end

    initial begin
        int per, st, ps, steps, reps, n;

        #2 reset_signal = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_state", sweep_state, ST_IDLE);
        check("rst_phase", phase_shift, 0);
        check("rst_step", step_index, 0);
        check("rst_enable", fsm_enable, 0);
        check("rst_start", fsm_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset_signal = 1'b1;

        // Basic sweep 0,40..200,0,40 with two triggers per step
        n_fsm_start = 0;
        run_cfg(0, 40, 240, 8, 2);
        check("t1_busy", busy, 1);
        wait_done(3000, "t1");
        check("t1_fsm_starts", n_fsm_start, 8);
        check("t1_final_phase", phase_shift, 40);
        check("t1_final_step", step_index, 7);
        check("t1_busy_done", busy, 0);

        // Exact modulo wrap 100,170,0,70
        run_cfg(100, 70, 240, 4, 1);
        wait_done(2000, "t2");
        check("t2_final_phase", phase_shift, 70);

        // Zero steps: LOAD then DONE, done three cycles after start, no fsm_start
        n_fsm_start = 0;
        @(negedge clock);
        cfg_steps = '0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t3_load_state", sweep_state, ST_LOAD);
        check("t3_done_cleared", done, 0);
        @(negedge clock);
        check("t3_done_state", sweep_state, ST_DONE);
        @(negedge clock);
        check("t3_done_level", done, 1);
        check("t3_no_fsm_start", n_fsm_start, 0);

        // Detector held not-ready keeps the sweep parked in SETTLE
        ready_mode = 1;
        detector_ready = 1'b0;
        run_cfg(20, 30, 240, 2, 1);
        wait_state(ST_SETTLE, 500, "t4_settle");
        repeat (200) @(negedge clock);
        check("t4_still_settle", sweep_state, ST_SETTLE);
        check("t4_enable_low", fsm_enable, 0);
        check("t4_step_held", step_index, 0);
        ready_mode = 2;
        detector_ready = 1'b1;
        @(negedge clock);
        check("t4_next_state", sweep_state, ST_NEXT);
        @(negedge clock);
        check("t4_fsm_start", fsm_start, 1);
        ready_mode = 0;
        wait_done(2000, "t4");

        // Abort coinciding with the second trigger edge of step 3
        abort_rise = 2;
        abort_step = 3;
        run_cfg(10, 50, 240, 6, 2);
        wait_state(ST_IDLE, 3000, "t5_abort");
        check("t5_done_low", done, 0);
        check("t5_step_held", step_index, 3);
        check("t5_phase_held", phase_shift, 160);
        check("t5_busy_low", busy, 0);
        check("t5_enable_low", fsm_enable, 0);
        abort_step = -1;
        sb_q.delete();
        run_cfg(10, 50, 240, 6, 2);
        wait_done(3000, "t5_rerun");
        check("t5_rerun_step", step_index, 5);
        check("t5_rerun_phase", phase_shift, 20);

        // Randomized sweeps; configuration is scrambled once the sweep has latched it
        for (int i = 0; i < 6; i++) begin
            per   = $urandom_range(2, 300);
            st    = $urandom_range(0, per - 1);
            ps    = $urandom_range(0, per - 1);
            steps = $urandom_range(1, 10);
            reps  = $urandom_range(0, 3);
            run_cfg(ps, st, per, steps, reps);
            @(negedge clock);
            cfg_phase_start  = PHASE_W'($urandom);
            cfg_phase_step   = PHASE_W'($urandom);
            cfg_phase_period = PHASE_W'($urandom);
            cfg_steps        = STEP_W'($urandom);
            cfg_repeats      = REPEAT_W'($urandom);
            wait_done(6000, "rand");
            check("rand_final_phase", phase_shift, (ps + (steps - 1) * st) % per);
            check("rand_final_step", step_index, steps - 1);
            check("rand_error_low", error, 0);
        end

        // Asynchronous reset in the middle of step 1
        run_cfg(30, 10, 240, 3, 3);
        n = 0;
        while (!(sweep_state == ST_RUN && step_index == 1) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("t6_run_step1", step_index, 1);
        #2 reset_signal = 1'b0;
        #1;
        check("t6_arst_enable", fsm_enable, 0);
        check("t6_arst_busy", busy, 0);
        check("t6_arst_state", sweep_state, ST_IDLE);
        check("t6_arst_phase", phase_shift, 0);
        check("t6_arst_step", step_index, 0);
        @(negedge clock);
        reset_signal = 1'b1;
        sb_q.delete();

`ifdef SWEEP_TIMEOUT_EN
        // No triggers: watchdog expires after 1000 cycles in RUN
        em_quiet = 1'b1;
        run_cfg(0, 10, 240, 2, 1);
        wait_state(ST_RUN, 10, "t7_run");
        n = 0;
        while (sweep_state != ST_ERROR && n < 1100) begin
            @(negedge clock);
            n++;
        end
        check("t7_timeout_cycles", n, 1000);
        check("t7_enable_low", fsm_enable, 0);
        @(negedge clock);
        check("t7_error_level", error, 1);
        check("t7_busy_low", busy, 0);
        em_quiet = 1'b0;
        sb_q.delete();
        run_cfg(0, 10, 240, 1, 1);
        check("t7_error_cleared", error, 0);
        wait_done(500, "t7_recover");
`endif

        check("final_queue_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
